// File: rtl/rv_core_pkg.sv
// Shared core definitions: datapath widths, requester IDs and a
// saturating-increment helper used by the register-file write arbiter.
package rv_core_pkg;

  localparam int REG_W       = 32;
  localparam int ADDR_W      = 5;
  localparam int STALL_CNT_W = 16;

  // Requester IDs: pipeline writeback and the multi-cycle unit.
  typedef enum logic {
    REQ_WB = 1'b0,
    REQ_MC = 1'b1
  } req_id_e;

  // Add one, sticking at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] value);
    if (value == {STALL_CNT_W{1'b1}}) begin
      return value;
    end
    return value + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational from the valids
// and a one-bit pointer holding the most recently granted requester.
// The pointer resets to REQ_MC so that REQ_WB wins the first conflict.
module rr_arb2
  import rv_core_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    valid0,
  input  logic    valid1,
  output logic    ready0,
  output logic    ready1,
  output logic    grant_valid,
  output req_id_e grant_id
);

  req_id_e last_grant;

  // Pick the winner: a lone requester wins, a conflict goes to whoever lost last time.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_WB;
    ready0      = 1'b0;
    ready1      = 1'b0;
    if (!rst) begin
      if (valid0 && valid1) begin
        grant_valid = 1'b1;
        grant_id    = (last_grant == REQ_WB) ? REQ_MC : REQ_WB;
      end else if (valid0) begin
        grant_valid = 1'b1;
        grant_id    = REQ_WB;
      end else if (valid1) begin
        grant_valid = 1'b1;
        grant_id    = REQ_MC;
      end
      ready0 = grant_valid && (grant_id == REQ_WB);
      ready1 = grant_valid && (grant_id == REQ_MC);
    end
  end

  // Remember the winner of every transfer; idle cycles leave the pointer alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_MC;
    end else if (grant_valid) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter. Two requesters (pipeline writeback and
// a multi-cycle unit) share one write port. The accepted write is
// registered onto wr_* one cycle later; writes to x0 are accepted but
// dropped. stall_cnt counts cycles in which a valid requester was refused.
module rf_wr_arbiter
  import rv_core_pkg::*;
#(
  parameter int N = REG_W,
  parameter int A = ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [A-1:0]           req0_addr,
  input  logic [N-1:0]           req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [A-1:0]           req1_addr,
  input  logic [N-1:0]           req1_data,
  output logic                   req1_ready,
  output logic                   wr_en,
  output logic [A-1:0]           wr_addr,
  output logic [N-1:0]           wr_data,
  output logic                   wr_src,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic         grant_valid;
  req_id_e      grant_id;
  logic [A-1:0] sel_addr;
  logic [N-1:0] sel_data;
  logic         stall;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .ready0      (req0_ready),
    .ready1      (req1_ready),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Route the winner's address/data and flag any refused valid requester.
  always_comb begin
    sel_addr = req0_addr;
    sel_data = req0_data;
    if (grant_id == REQ_MC) begin
      sel_addr = req1_addr;
      sel_data = req1_data;
    end
    stall = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);
  end

  // Register the accepted write; x0 transfers update the fields but never strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= 1'b0;
    end else begin
      wr_en <= grant_valid && (sel_addr != '0);
      if (grant_valid) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        wr_src  <= logic'(grant_id);
      end
    end
  end

  // Count refused cycles, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_rf_wr_arbiter;
  import rv_core_pkg::*;

  localparam int N = REG_W;
  localparam int A = ADDR_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid;
  logic [A-1:0] req0_addr;
  logic [N-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [A-1:0] req1_addr;
  logic [N-1:0] req1_data;
  logic         req1_ready;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [N-1:0] wr_data;
  logic         wr_src;
  logic [15:0]  stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int           m_last;
  logic         m_wr_en;
  logic [A-1:0] m_wr_addr;
  logic [N-1:0] m_wr_data;
  logic         m_wr_src;
  int           m_stall;

  rf_wr_arbiter #(.N(N), .A(A)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_src     (wr_src),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Winner this cycle per the arbitration rules; -1 when nobody is granted.
  function automatic int model_grant();
    if (rst) return -1;
    if (req0_valid && req1_valid) return 1 - m_last;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // Advance one clock and update the model with what the edge should do.
  task automatic tick();
    int g;
    logic [A-1:0] a;
    g = model_grant();
    @(posedge clk);
    if (rst) begin
      m_last    = 1;
      m_wr_en   = 1'b0;
      m_wr_addr = '0;
      m_wr_data = '0;
      m_wr_src  = 1'b0;
      m_stall   = 0;
    end else begin
      if ((req0_valid && g != 0) || (req1_valid && g != 1)) begin
        if (m_stall < 65535) m_stall = m_stall + 1;
      end
      if (g >= 0) begin
        a         = (g == 0) ? req0_addr : req1_addr;
        m_last    = g;
        m_wr_addr = a;
        m_wr_data = (g == 0) ? req0_data : req1_data;
        m_wr_src  = (g == 1);
        m_wr_en   = (a != '0);
      end else begin
        m_wr_en = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_addr  = 5'd7;
    req1_addr  = 5'd9;
    req0_data  = $urandom;
    req1_data  = $urandom;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
    tick();
    tick();
    n_cmp++;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || wr_src !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_wr: got en=%b addr=%0d data=%h src=%b expected all 0",
               wr_en, wr_addr, wr_data, wr_src);
    end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_stall: got %0d expected 0", stall_cnt);
    end
    rst        = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    req0_valid = 1'b1;
    req0_addr  = 5'd5;
    req0_data  = 32'hDEADBEEF;
    req1_valid = 1'b0;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF || wr_src !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_wr: got en=%b addr=%0d data=%h src=%b expected 1/5/deadbeef/0",
               wr_en, wr_addr, wr_data, wr_src);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[TB] FAIL single_hold: got en=%b addr=%0d data=%h expected 0/5/deadbeef",
               wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_first_conflict();
    logic [N-1:0] d0, d1;
    do_reset();
    d0 = $urandom;
    d1 = $urandom;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = d0;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = d1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL conflict_c1_ready: got %b%b expected 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    n_cmp++;
    if (stall_cnt !== 16'd1 || wr_addr !== 5'd3 || wr_data !== d0 || wr_src !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL conflict_c1_out: got stall=%0d addr=%0d data=%h src=%b expected 1/3/%h/0",
               stall_cnt, wr_addr, wr_data, wr_src, d0);
    end
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL conflict_c2_ready: got %b%b expected 01", req0_ready, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    n_cmp++;
    if (stall_cnt !== 16'd1 || wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== d1 || wr_src !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL conflict_c2_out: got stall=%0d en=%b addr=%0d data=%h src=%b expected 1/1/4/%h/1",
               stall_cnt, wr_en, wr_addr, wr_data, wr_src, d1);
    end
  endtask

  task automatic test_addr_zero();
    // Previous scenario ended with requester 1 granted.
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
    #1;
    n_cmp++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL x0_ready: got %b%b expected 01", req0_ready, req1_ready);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL x0_wr_en: got %b expected 0", wr_en);
    end
    // Pointer now says requester 1, so a conflict must go to requester 0.
    req0_valid = 1'b1; req0_addr = 5'd11; req0_data = $urandom;
    req1_addr  = 5'd12;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL x0_pointer: got %b%b expected 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd20; req0_data = $urandom;
    req1_valid = 1'b1; req1_addr = 5'd21; req1_data = $urandom;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        n_fail++;
        $display("[TB] FAIL b2b_ready[%0d]: got %b%b expected %b%b",
                 i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
      end
      tick();
      n_cmp++;
      if (wr_en !== 1'b1 || wr_src !== (i % 2 == 1)) begin
        n_fail++;
        $display("[TB] FAIL b2b_wr[%0d]: got en=%b src=%b expected 1/%b",
                 i, wr_en, wr_src, (i % 2 == 1));
      end
    end
    n_cmp++;
    if (stall_cnt !== 16'd6) begin
      n_fail++;
      $display("[TB] FAIL b2b_stall: got %0d expected 6", stall_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    // Both still valid from the previous scenario; requester 1 won last.
    rst = 1'b1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_rst_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b0 || stall_cnt !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_rst_out: got en=%b stall=%0d expected 0/0", wr_en, stall_cnt);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_rst_first: got %b%b expected 10", req0_ready, req1_ready);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b1 || wr_src !== 1'b0 || wr_addr !== 5'd20) begin
      n_fail++;
      $display("[TB] FAIL mid_rst_wr: got en=%b src=%b addr=%0d expected 1/0/20", wr_en, wr_src, wr_addr);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int   g;
    logic held0, held1;
    do_reset();
    held0 = 1'b0;
    held1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      // A refused requester keeps its request stable until accepted.
      rst = ($urandom_range(0, 39) == 0);
      if (!held0) begin
        req0_valid = $urandom_range(0, 2) != 0;
        req0_addr  = ($urandom_range(0, 7) == 0) ? '0 : A'($urandom);
        req0_data  = $urandom;
      end
      if (!held1) begin
        req1_valid = $urandom_range(0, 2) != 0;
        req1_addr  = ($urandom_range(0, 7) == 0) ? '0 : A'($urandom);
        req1_data  = $urandom;
      end
      #1;
      g = model_grant();
      n_cmp++;
      if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        n_fail++;
        $display("[TB] FAIL rand_ready[%0d]: got %b%b expected %b%b",
                 i, req0_ready, req1_ready, (g == 0), (g == 1));
      end
      held0 = req0_valid && (g != 0);
      held1 = req1_valid && (g != 1);
      tick();
      n_cmp++;
      if (wr_en !== m_wr_en || wr_addr !== m_wr_addr || wr_data !== m_wr_data ||
          wr_src !== m_wr_src || stall_cnt !== 16'(m_stall)) begin
        n_fail++;
        $display("[TB] FAIL rand_out[%0d]: got en=%b addr=%0d data=%h src=%b stall=%0d expected en=%b addr=%0d data=%h src=%b stall=%0d",
                 i, wr_en, wr_addr, wr_data, wr_src, stall_cnt,
                 m_wr_en, m_wr_addr, m_wr_data, m_wr_src, m_stall);
      end
    end
    rst        = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = $urandom;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = $urandom;
    for (int i = 0; i < 16'hFFFE; i++) tick();
    n_cmp++;
    if (stall_cnt !== 16'hFFFE) begin
      n_fail++;
      $display("[TB] FAIL sat_pre: got %h expected fffe", stall_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (stall_cnt !== 16'hFFFF || wr_en !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL sat_hold[%0d]: got stall=%h en=%b expected ffff/1", i, stall_cnt, wr_en);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_addr  = '0;
    req1_addr  = '0;
    req0_data  = '0;
    req1_data  = '0;
    m_last     = 1;
    m_wr_en    = 1'b0;
    m_wr_addr  = '0;
    m_wr_data  = '0;
    m_wr_src   = 1'b0;
    m_stall    = 0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_first_conflict();
    test_addr_zero();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter N, default 32, register data width in bits.
REQ-002 Parameter A, default 5, register address width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req0_valid  input  1  requester 0 (pipeline writeback) has a write pending.
REQ-006 req0_addr  input  A  destination register index for requester 0.
REQ-007 req0_data  input  N  write data for requester 0.
REQ-008 req0_ready  output  1  requester 0's write is accepted this cycle.
REQ-009 req1_valid / req1_addr / req1_data / req1_ready: same as REQ-005..008, for requester 1 (multi-cycle unit).
REQ-010 wr_en  output  1  register-file load strobe, registered.
REQ-011 wr_addr  output  A  registered write index.
REQ-012 wr_data  output  N  registered write data.
REQ-013 wr_src  output  1  ID of the requester that produced the current wr_en; 0 or 1.
REQ-014 stall_cnt  output  16  saturating count of cycles in which some valid requester was refused.

Function
REQ-015 A transfer on requester i SHALL occur when reqi_valid and reqi_ready are both 1 in the same cycle.
REQ-016 At most one reqi_ready SHALL be 1 per cycle; reqi_ready SHALL be combinational from the valids and the priority pointer.
REQ-017 Only one valid: that requester SHALL be granted.
REQ-018 Both valid: grant the requester not granted most recently (round-robin).
REQ-019 The one-bit pointer last_grant SHALL update to the granted ID on every transfer and SHALL hold otherwise.
REQ-020 Neither valid: both readys SHALL be 0, pointer unchanged.
REQ-021 A transfer SHALL appear on wr_en/wr_addr/wr_data/wr_src exactly one cycle later; latency is fixed at 1.
REQ-022 wr_en SHALL be 1 for exactly one cycle per accepted transfer with a nonzero address.
REQ-023 A transfer with address 0 SHALL be accepted (ready=1, pointer updates) and SHALL NOT assert wr_en, because x0 is hardwired.
REQ-024 In a cycle with no transfer, wr_en SHALL be 0; wr_addr, wr_data and wr_src SHALL hold their last values.
REQ-025 A refused requester's address and data are not captured; the requester SHALL keep valid asserted, and the block relies on inputs staying stable until accepted.
REQ-026 stall_cnt SHALL increment when (req0_valid & !req0_ready) | (req1_valid & !req1_ready), and SHALL saturate at 16'hFFFF.
REQ-027 Back-to-back transfers SHALL be supported every cycle, with no bubble inserted.

Reset
REQ-028 While rst=1, both readys SHALL be 0 and no transfer SHALL occur, regardless of the valids.
REQ-029 Reset values: wr_en=0, wr_addr=0, wr_data=0, wr_src=0, stall_cnt=0, last_grant=1, so requester 0 wins the first conflict.
REQ-030 An assertion of rst mid-stream SHALL discard any transfer presented in that cycle; wr_en SHALL be 0 in the following cycle.

Structure
REQ-031 Shared package rv_core_pkg SHALL hold REG_W=32, ADDR_W=5, STALL_CNT_W=16, and requester IDs REQ_WB=0 and REQ_MC=1.
REQ-032 The arbitration logic (grant plus pointer) SHALL be a sub-module rr_arb2; the output stage and counter SHALL stay in rf_wr_arbiter.
REQ-033 The wr_* outputs SHALL come directly from flops, with no combinational path from req* to wr_*.

Verification
REQ-034 After reset, req0 alone, addr 5, data 0xDEADBEEF -> next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, wr_src=0.
REQ-035 First conflict after reset, both valid (req0 addr 3, req1 addr 4), held 2 cycles -> cycle 1: req0_ready=1, stall_cnt=1; cycle 2: req1_ready=1, stall_cnt stays 1; wr_addr reads 3 then 4.
REQ-036 req1 alone, addr 0, data 0x1234 -> req1_ready=1, wr_en stays 0 the next cycle, last_grant=1.
REQ-037 Both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; wr_en=1 on 6 consecutive cycles; stall_cnt=6.
REQ-038 rst=1 while both valid -> both readys 0, wr_en=0 the next cycle, stall_cnt=0, and req0 wins the first cycle after reset.
REQ-039 Force stall_cnt to 0xFFFE, then hold a conflict for 3 cycles -> stall_cnt reaches 0xFFFF and stays there.
